mod_mul_check: RTL
==================

MOD_MUL_CHECK -- requirements
Module: mod_mul_check

Interface
REQ-001 SHALL have parameter: WIDTH, 256, operand/modulus width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on posedge.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous, active-high (asserted = 1).
REQ-004 SHALL have port: p  input  WIDTH  modulus, sampled with en.
REQ-005 SHALL have port: a  input  WIDTH  multiplicand, sampled with en.
REQ-006 SHALL have port: b  input  WIDTH  multiplier (e.g. inverse result), sampled with en.
REQ-007 SHALL have port: en  input  1  start pulse; p/a/b valid.
REQ-008 SHALL have port: ready  output  1  registered; high only in IDLE.
REQ-009 SHALL have port: valid  output  1  registered one-cycle completion pulse.
REQ-010 SHALL have port: result  output  WIDTH  registered (a*b) mod p.
REQ-011 SHALL have port: is_one  output  1  registered; result == 1 (see Configuration).

Function
REQ-012 SHALL compute result = (a*b) mod p with the MSB-first interleaved shift-add algorithm, one b bit per cycle.
REQ-013 SHALL require a < p, b < p, p >= 2 of the caller; otherwise result is unspecified, but latency and handshake are unchanged.
REQ-014 SHALL implement states IDLE, MUL, DONE; encoding 2 bits; unused codes go to IDLE next cycle.
REQ-015 In IDLE with en=1 at edge E0, SHALL latch p, a, b, clear accumulator r to 0, load bit counter to WIDTH-1, drop ready, and go to MUL.
REQ-016 In MUL, each edge SHALL compute t = 2r + (b[cnt] ? a : 0) in WIDTH+2 bits, subtract p when t >= p, subtract p again when still >= p, store into r, and decrement cnt.
REQ-017 On the MUL edge with cnt == 0 (edge E0+WIDTH), SHALL write the final r to result, set valid=1, and go to DONE.
REQ-018 In DONE, the next edge SHALL clear valid, set ready=1, and return to IDLE; valid is high for exactly one cycle.
REQ-019 Latency SHALL be fixed: valid rises WIDTH edges after the en-sampling edge, independent of operand values; throughput is one operation per WIDTH+2 cycles.
REQ-020 en outside IDLE SHALL be ignored, with no effect on state, operands or outputs.
REQ-021 Inputs p/a/b SHALL be sampled only at the en edge; later changes do not affect the operation in flight.
REQ-022 result and is_one SHALL hold their last values until the next completion overwrites them.
REQ-023 Intermediate r SHALL always remain < p; no truncation of the WIDTH+2-bit sum.

Reset
REQ-024 rst_n=1 at a clock edge SHALL force: state IDLE, ready=1, valid=0, result=0, is_one=0, r=0, cnt=0, latched operands=0.
REQ-025 Reset SHALL take priority over en and over any in-flight operation; an aborted operation produces no valid pulse.
REQ-026 An en coincident with reset SHALL be discarded.

Configuration
REQ-027 Macro MOD_MUL_CHECK_ONE_EN defined: is_one SHALL be registered together with result at completion as (final r == 1), used to confirm b as the modular inverse of a.
REQ-028 Macro MOD_MUL_CHECK_ONE_EN undefined: no comparator SHALL be built, and is_one SHALL be tied to constant 0; all other behaviour is identical.

Verification (WIDTH=8, MOD_MUL_CHECK_ONE_EN defined unless noted)
REQ-029 p=251, a=3, b=84, en pulse -> valid exactly 8 edges later, result=1, is_one=1, ready low for the 9 intervening cycles.
REQ-030 p=251, a=250, b=250 -> result=1, is_one=1; then p=251, a=10, b=20 -> result=200, is_one=0.
REQ-031 p=13, a=0, b=12 -> result=0, is_one=0; with the macro undefined, p=13, a=7, b=2 -> result=1, is_one=0.
REQ-032 en re-pulsed with other operands 3 cycles into an operation -> ignored; the original result is produced with the same latency and a single valid pulse.
REQ-033 rst_n asserted at cycle 4 of an operation -> next cycle ready=1, valid=0, result=0; no valid pulse follows; a fresh en then completes correctly.
REQ-034 Random back-to-back en on each ready, 10k operands with a,b < p -> result equals the (a*b) mod p reference model every time.

Source files
------------

// File: rtl/mod_mul_check.sv
// Modular multiply (a*b) mod p, MSB-first interleaved shift-add, one b bit per cycle; valid WIDTH cycles after en.
// No backpressure: ready low while busy and en is ignored then; MOD_MUL_CHECK_ONE_EN builds the result==1 flag.
module mod_mul_check #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             is_one
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, a_q, b_q, r_q, r_nxt;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH+1:0] p_ext, t, t1;
  logic             last;

  assign last = (cnt_q == '0);

  // Two conditional subtractions keep r < p since 2r + a < 3p.
  always_comb begin
    p_ext = {2'b00, p_q};
    t     = {1'b0, r_q, 1'b0} + (b_q[cnt_q] ? {2'b00, a_q} : '0);
    t1    = (t >= p_ext) ? (t - p_ext) : t;
    r_nxt = (t1 >= p_ext) ? WIDTH'(t1 - p_ext) : WIDTH'(t1);
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = en ? MUL : IDLE;
      MUL:     state_d = last ? DONE : MUL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      ready   <= 1'b1;
      valid   <= 1'b0;
      result  <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == IDLE);
      valid   <= (state_q == MUL) && last;
      case (state_q)
        IDLE: begin
          if (en) begin
            p_q   <= p;
            a_q   <= a;
            b_q   <= b;
            r_q   <= '0;
            cnt_q <= CW'(WIDTH - 1);
          end
        end
        MUL: begin
          r_q   <= r_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (last) result <= r_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef MOD_MUL_CHECK_ONE_EN
  always_ff @(posedge clk) begin
    if (rst_n)
      is_one <= 1'b0;
    else if ((state_q == MUL) && last)
      is_one <= (r_nxt == WIDTH'(1));
  end
`else
  assign is_one = 1'b0;
`endif

endmodule
